// File: rtl/hazard_forward_unit_gen.sv
// +--------------------------------------------------------------------------+
// | hazard_forward_unit_gen                                                  |
// | Operand forwarding selects and load-use stall control for a 5-stage      |
// | pipeline, driven by an internal EX/MEM/WB destination scoreboard.        |
// | Optional: define HAZARD_STALL_COUNT_EN to add a saturating stall counter.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module hazard_forward_unit_gen #(
    parameter int NUM_SRC     = 3,
    parameter int REG_W       = 5,
    parameter int ZERO_REG_HW = 1
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       id_valid,
    input  logic [REG_W-1:0]           id_rd,
    input  logic                       id_rf_en,
    input  logic                       id_load,
    input  logic [NUM_SRC*REG_W-1:0]   id_src,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic                       id_flush,
    output logic [2*NUM_SRC-1:0]       fwd_sel,
    output logic                       stall,
    output logic                       pc_le,
    output logic                       if_id_le,
    output logic                       bubble_sel
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [15:0]                stall_count
`endif
);

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             rf_en;
        logic             ld;
    } rec_t;

    rec_t ex_q, ex_d, mem_q, wb_q;
    logic [NUM_SRC-1:0] w_ld_use;

    // Load flags of the older stages are kept for record completeness only.
    logic w_unused;
    assign w_unused = ^{mem_q.ld, wb_q.ld};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_W-1:0] w_tag;
        logic             w_zero;
        logic             w_ex_hit;
        logic             w_mem_hit;
        logic             w_wb_hit;
        logic [1:0]       w_sel;

        assign w_tag     = id_src[i*REG_W +: REG_W];
        assign w_zero    = (ZERO_REG_HW != 0) && (w_tag == '0);
        assign w_ex_hit  = id_src_used[i] & ex_q.v  & ex_q.rf_en  & (ex_q.rd  == w_tag) & ~w_zero;
        assign w_mem_hit = id_src_used[i] & mem_q.v & mem_q.rf_en & (mem_q.rd == w_tag) & ~w_zero;
        assign w_wb_hit  = id_src_used[i] & wb_q.v  & wb_q.rf_en  & (wb_q.rd  == w_tag) & ~w_zero;

        // A load in EX has no data yet, so it is skipped and older stages may still supply.
        always_comb begin
            w_sel = 2'd0;
            if (w_ex_hit && !ex_q.ld) begin
                w_sel = 2'd3;
            end else if (w_mem_hit) begin
                w_sel = 2'd2;
            end else if (w_wb_hit) begin
                w_sel = 2'd1;
            end
        end

        assign fwd_sel[2*i +: 2] = w_sel;
        assign w_ld_use[i]       = w_ex_hit & ex_q.ld;
    end

    assign stall      = id_valid & ~id_flush & (|w_ld_use);
    assign pc_le      = ~stall;
    assign if_id_le   = ~stall;
    assign bubble_sel = stall;

    always_comb begin
        ex_d = '0;
        if (id_valid && !id_flush && !stall) begin
            ex_d = {1'b1, id_rd, id_rf_en, id_load};
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [15:0] stall_count_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stall_count_q <= 16'd0;
        end else if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_forward_unit_gen.sv
// Randomized plus directed bench for hazard_forward_unit_gen against a
// list-of-instructions reference model.
`default_nettype none

module tb_hazard_forward_unit_gen;

    localparam int NS = 3;
    localparam int RW = 5;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic             id_valid = 1'b0;
    logic [RW-1:0]    id_rd = '0;
    logic             id_rf_en = 1'b0;
    logic             id_load = 1'b0;
    logic [NS*RW-1:0] id_src = '0;
    logic [NS-1:0]    id_src_used = '0;
    logic             id_flush = 1'b0;
    logic [2*NS-1:0]  fwd_sel;
    logic             stall, pc_le, if_id_le, bubble_sel;
`ifdef HAZARD_STALL_COUNT_EN
    logic [15:0]      stall_count;
`endif

    hazard_forward_unit_gen #(.NUM_SRC(NS), .REG_W(RW), .ZERO_REG_HW(1)) dut (
        .clk        (clk),
        .clr        (clr),
        .id_valid   (id_valid),
        .id_rd      (id_rd),
        .id_rf_en   (id_rf_en),
        .id_load    (id_load),
        .id_src     (id_src),
        .id_src_used(id_src_used),
        .id_flush   (id_flush),
        .fwd_sel    (fwd_sel),
        .stall      (stall),
        .pc_le      (pc_le),
        .if_id_le   (if_id_le),
        .bubble_sel (bubble_sel)
`ifdef HAZARD_STALL_COUNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: in-flight instructions, index 0 = youngest (EX), 2 = oldest (WB).
    int m_v[3], m_rd[3], m_rf[3], m_ld[3];
    int m_cnt;
    int e_sel[NS];
    int e_stall;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int s = 0; s < 3; s++) begin
            m_v[s] = 0; m_rd[s] = 0; m_rf[s] = 0; m_ld[s] = 0;
        end
        m_cnt = 0;
    endtask

    // Youngest in-flight writer of the tag supplies data; a load that is
    // still in EX cannot, so the consumer must wait one cycle.
    task automatic model_eval(input int v, input int fl, input int src[NS], input int used[NS]);
        int ldu;
        ldu = 0;
        for (int i = 0; i < NS; i++) begin
            e_sel[i] = 0;
            if (used[i] != 0 && src[i] != 0) begin
                for (int s = 0; s < 3; s++) begin
                    if (m_v[s] != 0 && m_rf[s] != 0 && m_rd[s] == src[i]) begin
                        if (s == 0 && m_ld[0] != 0) begin
                            ldu = 1;
                        end else begin
                            e_sel[i] = 3 - s;
                            break;
                        end
                    end
                end
            end
        end
        e_stall = (v != 0 && fl == 0 && ldu != 0) ? 1 : 0;
    endtask

    task automatic check_outputs(input string ph);
        for (int i = 0; i < NS; i++)
            chk($sformatf("%s fwd%0d", ph, i), int'(fwd_sel[2*i +: 2]), e_sel[i]);
        chk({ph, " stall"}, int'(stall), e_stall);
        chk({ph, " pc_le"}, int'(pc_le), 1 - e_stall);
        chk({ph, " if_id_le"}, int'(if_id_le), 1 - e_stall);
        chk({ph, " bubble_sel"}, int'(bubble_sel), e_stall);
`ifdef HAZARD_STALL_COUNT_EN
        chk({ph, " stall_count"}, int'(stall_count), m_cnt);
`endif
    endtask

    task automatic cycle(input int v, input int rd, input int rf, input int ld,
                         input int s0, input int s1, input int s2,
                         input int used, input int fl, input int do_clr);
        int src[NS];
        int u[NS];
        src[0] = s0; src[1] = s1; src[2] = s2;
        for (int i = 0; i < NS; i++) u[i] = (used >> i) & 1;
        @(negedge clk);
        id_valid    = v[0];
        id_rd       = rd[RW-1:0];
        id_rf_en    = rf[0];
        id_load     = ld[0];
        id_src      = {s2[RW-1:0], s1[RW-1:0], s0[RW-1:0]};
        id_src_used = used[NS-1:0];
        id_flush    = fl[0];
        #1;
        model_eval(v, fl, src, u);
        check_outputs("run");
        if (do_clr != 0) begin
            clr = 1'b1;
            #1;
            model_clear();
            model_eval(v, fl, src, u);
            check_outputs("clr");
            clr = 1'b0;
        end
        @(posedge clk);
        for (int s = 2; s > 0; s--) begin
            m_v[s] = m_v[s-1]; m_rd[s] = m_rd[s-1]; m_rf[s] = m_rf[s-1]; m_ld[s] = m_ld[s-1];
        end
        if (v != 0 && fl == 0 && e_stall == 0) begin
            m_v[0] = 1; m_rd[0] = rd; m_rf[0] = rf; m_ld[0] = ld;
        end else begin
            m_v[0] = 0; m_rd[0] = 0; m_rf[0] = 0; m_ld[0] = 0;
        end
        if (e_stall != 0 && m_cnt < 65535) m_cnt++;
    endtask

    initial begin
        model_clear();
        for (int i = 0; i < NS; i++) e_sel[i] = 0;
        e_stall = 0;
        #2;
        check_outputs("reset");
        @(negedge clk);
        clr = 1'b0;

        // Directed: empty scoreboard, forwarding age sweep, load-use, flush, zero tag, clr.
        cycle(1, 0, 0, 0, 5, 0, 0, 3'b001, 0, 0);
        cycle(1, 5, 1, 0, 0, 0, 0, 3'b000, 0, 0);
        cycle(1, 0, 0, 0, 5, 5, 0, 3'b011, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 5, 3'b100, 0, 0);
        cycle(1, 0, 0, 0, 5, 0, 0, 3'b001, 0, 0);
        cycle(1, 0, 0, 0, 5, 0, 0, 3'b001, 0, 0);
        cycle(1, 7, 1, 1, 0, 0, 0, 3'b000, 0, 0);
        cycle(1, 9, 1, 0, 0, 7, 0, 3'b010, 0, 0);
        cycle(1, 9, 1, 0, 0, 7, 0, 3'b010, 0, 0);
        cycle(1, 7, 1, 1, 0, 0, 0, 3'b000, 0, 0);
        cycle(1, 9, 1, 0, 0, 7, 0, 3'b010, 1, 0);
        cycle(1, 9, 1, 0, 0, 7, 0, 3'b010, 0, 0);
        cycle(1, 0, 1, 0, 0, 0, 0, 3'b000, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 7, 1, 1, 0, 0, 0, 3'b000, 0, 0);
            cycle(1, 9, 1, 0, 7, 0, 0, 3'b001, 0, 0);
            cycle(1, 9, 1, 0, 7, 0, 0, 3'b001, 0, 0);
        end
        cycle(1, 7, 1, 1, 0, 0, 0, 3'b000, 0, 0);
        cycle(1, 9, 1, 0, 7, 0, 0, 3'b001, 0, 1);
        cycle(1, 3, 1, 0, 7, 0, 0, 3'b001, 0, 0);

        // Random traffic over a small tag pool so hits and hazards are frequent.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 9) != 0) ? 1 : 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0) ? 1 : 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) == 0) ? 1 : 0,
                  ($urandom_range(0, 99) == 0) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
